// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM field widths, address split offsets and read FSM encoding
package sdram_pkg;

  // Engine field widths
  localparam int ROW_W  = 13;
  localparam int COL_W  = 10;
  localparam int BANK_W = 2;
  localparam int DATA_W = 16;

  // Linear word address split {bank, row, col}; shared with the write sequencer
  localparam int COL_LSB    = 0;
  localparam int ROW_LSB    = COL_LSB + COL_W;
  localparam int BANK_LSB   = ROW_LSB + ROW_W;
  localparam int LIN_ADDR_W = BANK_LSB + BANK_W;

  // Longest burst a single command may request
  localparam int MAX_BURST = 16;

  // Read sequencer states
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_FIN  = 3'd2,
    ST_HOLD      = 3'd3,
    ST_WAIT_DROP = 3'd4
  } rd_seq_state_e;

endpackage

// File: rtl/sdram_addr_inc.sv
// rtl/sdram_addr_inc.sv - combinational bank/row/col +1 with carry chain (wraps at the top)
module sdram_addr_inc
  import sdram_pkg::*;
(
  input  logic [BANK_W-1:0] bank,
  input  logic [ROW_W-1:0]  row,
  input  logic [COL_W-1:0]  col,
  output logic [BANK_W-1:0] bank_next,
  output logic [ROW_W-1:0]  row_next,
  output logic [COL_W-1:0]  col_next
);

  logic col_carry;
  logic row_carry;

  // Column always steps; a full column carries into row, a full row into bank
  always_comb begin
    col_carry = &col;
    row_carry = col_carry & (&row);
    col_next  = col + COL_W'(1);
    row_next  = col_carry ? row + ROW_W'(1) : row;
    bank_next = row_carry ? bank + BANK_W'(1) : bank;
  end

endmodule

// File: rtl/sdram_read_seq.sv
// rtl/sdram_read_seq.sv - burst read sequencer in front of the single-word SDRAM read engine (option: SDRAM_RD_SEQ_TIMEOUT_EN)
module sdram_read_seq
  import sdram_pkg::*;
#(
  parameter int ADDR_W = 25,
  parameter int LEN_W  = 5
`ifdef SDRAM_RD_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic              iclk,
  input  logic              ctr_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              rd_req,
  output logic              rd_en,
  output logic              rd_reset,
  output logic [ROW_W-1:0]  rd_row,
  output logic [COL_W-1:0]  rd_col,
  output logic [BANK_W-1:0] rd_bank,
  input  logic              rd_fin,
  input  logic [DATA_W-1:0] rd_data
`ifdef SDRAM_RD_SEQ_TIMEOUT_EN
  ,
  output logic              err
`endif
);

  rd_seq_state_e     state, state_n;
  logic              busy_n, rd_en_n, rd_req_n, rd_reset_n, cmd_ready_n;
  logic              out_valid_n, out_last_n;
  logic [DATA_W-1:0] out_data_n;
  logic [BANK_W-1:0] bank_n, inc_bank;
  logic [ROW_W-1:0]  row_n, inc_row;
  logic [COL_W-1:0]  col_n, inc_col;
  logic [LEN_W-1:0]  remaining, remaining_n;
  logic [LEN_W-1:0]  len_words;

`ifdef SDRAM_RD_SEQ_TIMEOUT_EN
  localparam int TIMER_W = $clog2(TIMEOUT);
  logic [TIMER_W-1:0] timer, timer_n;
  logic               err_n;
`endif

  // The address outputs double as the burst address register
  sdram_addr_inc u_addr_inc (
    .bank      (rd_bank),
    .row       (rd_row),
    .col       (rd_col),
    .bank_next (inc_bank),
    .row_next  (inc_row),
    .col_next  (inc_col)
  );

  // Word count for a new command: 0 means one word, oversize lengths clamp
  always_comb begin
    if (cmd_len == '0)
      len_words = LEN_W'(1);
    else if (cmd_len > LEN_W'(MAX_BURST))
      len_words = LEN_W'(MAX_BURST);
    else
      len_words = cmd_len;
  end

  // Next-state and next registered output values
  always_comb begin
    state_n     = state;
    busy_n      = busy;
    rd_en_n     = rd_en;
    cmd_ready_n = cmd_ready;
    rd_req_n    = 1'b0;
    rd_reset_n  = 1'b0;
    out_valid_n = out_valid;
    out_last_n  = out_last;
    out_data_n  = out_data;
    bank_n      = rd_bank;
    row_n       = rd_row;
    col_n       = rd_col;
    remaining_n = remaining;
`ifdef SDRAM_RD_SEQ_TIMEOUT_EN
    timer_n     = timer;
    err_n       = err;
`endif
    case (state)
      ST_IDLE: begin
        // rd_reset high means the engine is still being reset; hold off
        if (cmd_valid && cmd_ready && !rd_reset) begin
          bank_n      = cmd_addr[BANK_LSB +: BANK_W];
          row_n       = cmd_addr[ROW_LSB +: ROW_W];
          col_n       = cmd_addr[COL_LSB +: COL_W];
          remaining_n = len_words;
          busy_n      = 1'b1;
          rd_en_n     = 1'b1;
          cmd_ready_n = 1'b0;
          rd_req_n    = 1'b1;
          state_n     = ST_REQ;
`ifdef SDRAM_RD_SEQ_TIMEOUT_EN
          err_n       = 1'b0;
`endif
        end
      end
      ST_REQ: begin
        state_n = ST_WAIT_FIN;
`ifdef SDRAM_RD_SEQ_TIMEOUT_EN
        timer_n = '0;
`endif
      end
      ST_WAIT_FIN: begin
        if (rd_fin) begin
          out_data_n  = rd_data;
          out_valid_n = 1'b1;
          out_last_n  = (remaining == LEN_W'(1));
          state_n     = ST_HOLD;
        end
`ifdef SDRAM_RD_SEQ_TIMEOUT_EN
        else if (timer == TIMER_W'(TIMEOUT - 1)) begin
          // Engine stuck: pulse its reset and drop the rest of the burst
          rd_reset_n  = 1'b1;
          err_n       = 1'b1;
          busy_n      = 1'b0;
          rd_en_n     = 1'b0;
          cmd_ready_n = 1'b1;
          remaining_n = '0;
          state_n     = ST_IDLE;
        end else begin
          timer_n = timer + TIMER_W'(1);
        end
`endif
      end
      ST_HOLD: begin
        // rd_fin may still be high here; the next request waits for it to drop
        if (out_ready && out_valid) begin
          out_valid_n = 1'b0;
          out_last_n  = 1'b0;
          remaining_n = remaining - LEN_W'(1);
          bank_n      = inc_bank;
          row_n       = inc_row;
          col_n       = inc_col;
          state_n     = ST_WAIT_DROP;
        end
      end
      ST_WAIT_DROP: begin
        if (!rd_fin) begin
          if (remaining != '0) begin
            rd_req_n = 1'b1;
            state_n  = ST_REQ;
          end else begin
            busy_n      = 1'b0;
            rd_en_n     = 1'b0;
            cmd_ready_n = 1'b1;
            state_n     = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and output registers; reset holds the engine in reset
  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      rd_en     <= 1'b0;
      rd_req    <= 1'b0;
      rd_reset  <= 1'b1;
      cmd_ready <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      rd_bank   <= '0;
      rd_row    <= '0;
      rd_col    <= '0;
      remaining <= '0;
`ifdef SDRAM_RD_SEQ_TIMEOUT_EN
      timer     <= '0;
      err       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      busy      <= busy_n;
      rd_en     <= rd_en_n;
      rd_req    <= rd_req_n;
      rd_reset  <= rd_reset_n;
      cmd_ready <= cmd_ready_n;
      out_valid <= out_valid_n;
      out_last  <= out_last_n;
      out_data  <= out_data_n;
      rd_bank   <= bank_n;
      rd_row    <= row_n;
      rd_col    <= col_n;
      remaining <= remaining_n;
`ifdef SDRAM_RD_SEQ_TIMEOUT_EN
      timer     <= timer_n;
      err       <= err_n;
`endif
    end
  end

endmodule

// File: tb/tb_sdram_read_seq.sv
// tb/tb_sdram_read_seq.sv - self-checking bench for sdram_read_seq with engine model and scoreboard
module tb_sdram_read_seq;

  logic        iclk = 1'b0;
  logic        ctr_reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [24:0] cmd_addr;
  logic [4:0]  cmd_len;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        rd_req;
  logic        rd_en;
  logic        rd_reset;
  logic [12:0] rd_row;
  logic [9:0]  rd_col;
  logic [1:0]  rd_bank;
  logic        rd_fin;
  logic [15:0] rd_data;
`ifdef SDRAM_RD_SEQ_TIMEOUT_EN
  logic        err;
`endif

  sdram_read_seq dut (
    .iclk      (iclk),
    .ctr_reset (ctr_reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .rd_req    (rd_req),
    .rd_en     (rd_en),
    .rd_reset  (rd_reset),
    .rd_row    (rd_row),
    .rd_col    (rd_col),
    .rd_bank   (rd_bank),
    .rd_fin    (rd_fin),
    .rd_data   (rd_data)
`ifdef SDRAM_RD_SEQ_TIMEOUT_EN
    ,
    .err       (err)
`endif
  );

  always #5 iclk = ~iclk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Shared knobs for the stimulus processes
  int          rdy_mode = 1;     // 0 random, 1 always ready, 2 stalled
  int          fixed_lat = 0;    // 0 = random engine latency
  bit          eng_dead = 1'b0;  // engine never answers
  bit          use_fixed = 1'b0;
  logic [15:0] fixed_data = 16'hBEEF;

  function automatic logic [15:0] mem_word(input int ai);
    logic [24:0] a;
    a = 25'(ai);
    if (use_fixed) return fixed_data;
    return a[15:0] ^ {a[24:16], a[6:0]} ^ 16'h5A3C;
  endfunction

  typedef struct {
    int          addr;
    logic [15:0] data;
    bit          last;
  } word_t;

  word_t exp_q[$];
  int    req_q[$];
  int    req_seen = 0;
  int    words_seen = 0;
  int    last_bank = 0, last_row = 0, last_col = 0;

  // Expected stream for one command: consecutive linear addresses mod 2^25
  task automatic push_expect(input logic [24:0] a, input logic [4:0] len);
    int n;
    int ad;
    n = (len == 0) ? 1 : ((len > 16) ? 16 : int'(len));
    for (int i = 0; i < n; i++) begin
      ad = (int'(a) + i) % 33554432;
      req_q.push_back(ad);
      exp_q.push_back('{addr: ad, data: mem_word(ad), last: (i == n - 1)});
    end
  endtask

  // Engine model: answers a request after a latency, holds fin, then drops it
  int          eng_st = 0;
  int          eng_cnt = 0;
  int          eng_addr = 0;
  initial begin
    rd_fin  = 1'b0;
    rd_data = 16'h0;
    forever begin
      @(posedge iclk);
      #1;
      if (ctr_reset || rd_reset) begin
        rd_fin = 1'b0;
        eng_st = 0;
      end else begin
        case (eng_st)
          0: if (rd_req && !eng_dead) begin
            eng_addr = int'({rd_bank, rd_row, rd_col});
            eng_cnt  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
            eng_st   = 1;
          end
          1: if (eng_cnt <= 1) begin
            rd_fin  = 1'b1;
            rd_data = mem_word(eng_addr);
            eng_cnt = int'($urandom_range(1, 3));
            eng_st  = 2;
          end else eng_cnt--;
          default: if (eng_cnt <= 1) begin
            rd_fin = 1'b0;
            eng_st = 0;
          end else eng_cnt--;
        endcase
      end
    end
  end

  // Consumer ready driver
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge iclk);
      #1;
      case (rdy_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: requests against expected addresses, words against scoreboard
  bit          prev_hold = 1'b0;
  logic [15:0] prev_data = 16'h0;
  always @(negedge iclk) begin
    if (ctr_reset) begin
      prev_hold = 1'b0;
    end else begin
      if (rd_req) begin
        req_seen++;
        last_bank = int'(rd_bank);
        last_row  = int'(rd_row);
        last_col  = int'(rd_col);
        check("req_expected", 32'(req_q.size() > 0), 1);
        if (req_q.size() > 0) begin
          int a;
          a = req_q.pop_front();
          check("req_bank", 32'(rd_bank), a / 8388608);
          check("req_row", 32'(rd_row), (a / 1024) % 8192);
          check("req_col", 32'(rd_col), a % 1024);
        end
        check("req_while_valid", 32'(out_valid), 0);
        check("req_rd_en", 32'(rd_en), 1);
      end
      if (prev_hold && out_valid)
        check("hold_data_stable", 32'(out_data), 32'(prev_data));
      if (out_valid && out_ready) begin
        words_seen++;
        check("word_expected", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          word_t e;
          e = exp_q.pop_front();
          check("word_data", 32'(out_data), 32'(e.data));
          check("word_last", 32'(out_last), 32'(e.last));
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic send_cmd(input logic [24:0] a, input logic [4:0] len);
    int budget = 0;
    while (!(cmd_ready && !rd_reset) && budget < 200) begin
      @(posedge iclk);
      #2;
      budget++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 1);
    push_expect(a, len);
    cmd_addr  = a;
    cmd_len   = len;
    cmd_valid = 1'b1;
    @(posedge iclk);
    #2;
    cmd_valid = 1'b0;
    check("accept_busy", 32'(busy), 1);
    check("accept_cmd_ready", 32'(cmd_ready), 0);
    check("accept_rd_en", 32'(rd_en), 1);
    check("accept_req_latency", 32'(rd_req), 1);
  endtask

  task automatic wait_done();
    int budget = 0;
    while (busy && budget < 3000) begin
      @(posedge iclk);
      #2;
      budget++;
    end
    check("burst_done", 32'(busy), 0);
    check("idle_cmd_ready", 32'(cmd_ready), 1);
    check("idle_rd_en", 32'(rd_en), 0);
    check("scoreboard_drained", exp_q.size(), 0);
  endtask

  typedef struct {
    logic [24:0] addr;
    logic [4:0]  len;
    int          rdy;
    bit          fixed;
    int          exp_words;
    int          exp_bank;
    int          exp_row;
    int          exp_col;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int w0;
    int r0;
    int budget;
    logic [15:0] held;
    logic [24:0] ra;
    logic [4:0]  rl;

    tbl[0] = '{25'h0000005, 5'd1,  1, 1'b1, 1,  0, 0, 5};
    tbl[1] = '{25'h00003FE, 5'd4,  0, 1'b0, 4,  0, 1, 1};
    tbl[2] = '{25'h1FFFFFF, 5'd2,  1, 1'b0, 2,  0, 0, 0};
    tbl[3] = '{25'h0000123, 5'd0,  0, 1'b0, 1,  0, 0, 32'h123};
    tbl[4] = '{25'h17FFFF8, 5'd16, 0, 1'b0, 16, 3, 0, 7};

    ctr_reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = 25'h0;
    cmd_len   = 5'h0;
    repeat (3) @(posedge iclk);
    #2;
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    check("rst_rd_reset", 32'(rd_reset), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_rd_en", 32'(rd_en), 0);
    check("rst_rd_req", 32'(rd_req), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_addr", 32'({rd_bank, rd_row, rd_col}), 0);
`ifdef SDRAM_RD_SEQ_TIMEOUT_EN
    check("rst_err", 32'(err), 0);
`endif
    ctr_reset = 1'b0;
    #1;
    check("release_rd_reset_held", 32'(rd_reset), 1);
    @(posedge iclk);
    #2;
    check("release_rd_reset_drop", 32'(rd_reset), 0);
    check("release_cmd_ready", 32'(cmd_ready), 1);

    // Directed table
    for (int i = 0; i < 5; i++) begin
      rdy_mode  = tbl[i].rdy;
      use_fixed = tbl[i].fixed;
      w0 = words_seen;
      send_cmd(tbl[i].addr, tbl[i].len);
      wait_done();
      check("tbl_words", words_seen - w0, tbl[i].exp_words);
      check("tbl_last_bank", last_bank, tbl[i].exp_bank);
      check("tbl_last_row", last_row, tbl[i].exp_row);
      check("tbl_last_col", last_col, tbl[i].exp_col);
    end
    use_fixed = 1'b0;

    // Randomized bursts, biased toward column carries
    rdy_mode = 0;
    for (int i = 0; i < 20; i++) begin
      ra = 25'($urandom_range(0, 33554431));
      if ($urandom_range(0, 2) == 0) ra[9:0] = 10'h3F0 | 10'($urandom_range(0, 15));
      rl = 5'($urandom_range(0, 16));
      w0 = words_seen;
      send_cmd(ra, rl);
      wait_done();
      check("rand_words", words_seen - w0, (rl == 0) ? 1 : int'(rl));
    end

    // Backpressure: stall the consumer after the first word
    rdy_mode = 2;
    w0 = words_seen;
    send_cmd(25'h0000100, 5'd3);
    budget = 0;
    while (!out_valid && budget < 50) begin
      @(posedge iclk);
      #2;
      budget++;
    end
    check("bp_first_valid", 32'(out_valid), 1);
    r0 = req_seen;
    held = out_data;
    for (int i = 0; i < 10; i++) begin
      @(posedge iclk);
      #2;
      check("bp_valid_held", 32'(out_valid), 1);
      check("bp_data_held", 32'(out_data), 32'(held));
      check("bp_no_req", 32'(rd_req), 0);
    end
    check("bp_req_count", req_seen, r0);
    rdy_mode = 1;
    wait_done();
    check("bp_words", words_seen - w0, 3);

    // Reset while word 2 of 8 is outstanding at the engine
    fixed_lat = 5;
    r0 = req_seen;
    send_cmd(25'h0002000, 5'd8);
    budget = 0;
    while (req_seen < r0 + 2 && budget < 200) begin
      @(posedge iclk);
      #2;
      budget++;
    end
    check("mid_second_req", req_seen, r0 + 2);
    @(posedge iclk);
    #2;
    check("mid_in_wait_busy", 32'(busy), 1);
    check("mid_in_wait_valid", 32'(out_valid), 0);
    ctr_reset = 1'b1;
    #1;
    exp_q.delete();
    req_q.delete();
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_rd_en", 32'(rd_en), 0);
    check("mid_rst_rd_reset", 32'(rd_reset), 1);
    check("mid_rst_busy", 32'(busy), 0);
    repeat (2) @(posedge iclk);
    #2;
    ctr_reset = 1'b0;
    #1;
    check("mid_release_rd_reset", 32'(rd_reset), 1);
    check("mid_release_cmd_ready", 32'(cmd_ready), 1);
    @(posedge iclk);
    #2;
    check("mid_after_rd_reset", 32'(rd_reset), 0);
    fixed_lat = 0;
    w0 = words_seen;
    send_cmd(25'h0000040, 5'd2);
    wait_done();
    check("mid_recover_words", words_seen - w0, 2);

`ifdef SDRAM_RD_SEQ_TIMEOUT_EN
    // Engine never finishes: watchdog aborts the burst
    begin
      int first = 0;
      int pulses = 0;
      bit saw_valid = 1'b0;
      eng_dead = 1'b1;
      send_cmd(25'h0000300, 5'd1);
      for (int k = 1; k <= 80; k++) begin
        @(posedge iclk);
        #2;
        if (out_valid) saw_valid = 1'b1;
        if (rd_reset) begin
          if (first == 0) first = k;
          pulses++;
        end
      end
      check("to_first_reset_cycle", first, 65);
      check("to_reset_pulses", pulses, 1);
      check("to_no_valid", 32'(saw_valid), 0);
      check("to_err", 32'(err), 1);
      check("to_idle_busy", 32'(busy), 0);
      check("to_idle_ready", 32'(cmd_ready), 1);
      exp_q.delete();
      eng_dead = 1'b0;
      send_cmd(25'h0000301, 5'd1);
      check("to_err_cleared", 32'(err), 0);
      wait_done();
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
